// File: rtl/erbium_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// erbium_dispatch_pkg
// Shared definitions for the NFA/query dispatcher:
//   state_t     - dispatcher FSM states (IDLE, LOAD_NFA, STREAM_QUERY)
//   TTYPE_NFA   - s_axis_ttype value marking NFA edge lines
//   TTYPE_QUERY - s_axis_ttype value marking query lines
// -----------------------------------------------------------------------------
package erbium_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    LOAD_NFA     = 2'd1,
    STREAM_QUERY = 2'd2
  } state_t;

  localparam logic TTYPE_NFA   = 1'b0;
  localparam logic TTYPE_QUERY = 1'b1;

endpackage

// File: rtl/axis_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry registered buffer between a valid/ready producer and consumer.
// in_ready is a function of the occupancy register only, so the upstream
// ready never depends combinationally on out_ready. With one entry held and
// out_ready high, a push and a pop happen in the same cycle, giving a
// sustained rate of one word per cycle.
//
// Handshake: a word moves when valid and ready are both high on a rising
// clock edge; a producer holding valid keeps its word stable until it moves.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (flushes contents)
//   in_valid/ready  upstream handshake
//   in_data  [W]    upstream word
//   out_valid/ready downstream handshake
//   out_data [W]    downstream word (head entry)
// -----------------------------------------------------------------------------
module axis_skid_buffer #(
  parameter int W = 513
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] slot0;  // head entry, always the one presented downstream
  logic [W-1:0] slot1;  // second entry, only occupied when count == 2
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = slot0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            slot0 <= in_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            slot0 <= in_data;
          end else if (push) begin
            slot1 <= in_data;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        2'd2: begin
          // Full: in_ready is low, so only a pop can happen here.
          if (pop) begin
            slot0 <= slot1;
            count <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/nfa_query_dispatcher.sv
// -----------------------------------------------------------------------------
// nfa_query_dispatcher
// Splits the typed input stream: NFA edge lines (ttype 0) are written
// sequentially into the edge memory, query lines (ttype 1) are forwarded to
// the matching engine through a 2-entry skid buffer. Reports load completion
// and sticky protocol errors.
//
// Handshake: s_axis and m_axis follow AXI4-Stream rules; a beat transfers on a
// rising edge where valid and ready are both high, and a source holding valid
// keeps its payload stable until the transfer happens.
//
// Optional feature: define DISPATCHER_STATS_EN to add the 32-bit beat counters
// stat_nfa_lines and stat_query_lines (accepted beats per ttype, including
// dropped beats, wrapping).
//
// Ports:
//   aclk, areset           clock, synchronous active-high reset
//   s_axis_*               input stream (tvalid, tready, tdata, tlast, ttype)
//   mem_wr_en/addr/data    registered edge-memory write port
//   nfa_loaded             one-cycle pulse, one cycle after the final write
//   nfa_num_lines          line count of the last completed load
//   nfa_valid              at least one load completed since reset
//   m_axis_*               query output stream (tvalid, tready, tdata, tlast)
//   err_overflow           sticky: load exceeded memory depth
//   err_type               sticky: ttype changed inside a transfer
//   err_no_nfa             sticky: query started with nfa_valid low
//   dbg_state              current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module nfa_query_dispatcher
  import erbium_dispatch_pkg::*;
#(
  parameter int C_DATA_WIDTH     = 512,
  parameter int C_MEM_ADDR_WIDTH = 10
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_ttype,
  output logic                        mem_wr_en,
  output logic [C_MEM_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [C_DATA_WIDTH-1:0]     mem_wr_data,
  output logic                        nfa_loaded,
  output logic [C_MEM_ADDR_WIDTH:0]   nfa_num_lines,
  output logic                        nfa_valid,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        err_overflow,
  output logic                        err_type,
  output logic                        err_no_nfa,
  output logic [1:0]                  dbg_state
`ifdef DISPATCHER_STATS_EN
  ,
  output logic [31:0]                 stat_nfa_lines,
  output logic [31:0]                 stat_query_lines
`endif
);

  state_t state;
  state_t state_next;

  // wr_ptr is one bit wider than the address so it can hold the full depth;
  // its top bit set means the memory is full and further beats are dropped.
  logic [C_MEM_ADDR_WIDTH:0] wr_ptr;
  logic                      mem_full;
  logic                      load_done;   // set with the final write strobe
  logic                      first_beat;  // next accepted query beat is first

  logic accept;
  logic nfa_beat;
  logic query_beat;
  logic type_mismatch;

  logic                    skid_in_valid;
  logic                    skid_in_ready;
  logic                    skid_out_valid;
  logic [C_DATA_WIDTH:0]   skid_out_data;

  assign mem_full  = wr_ptr[C_MEM_ADDR_WIDTH];
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and input ready
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        // The first beat is only observed here, not consumed.
        if (s_axis_tvalid) begin
          state_next = (s_axis_ttype == TTYPE_QUERY) ? STREAM_QUERY : LOAD_NFA;
        end
      end
      LOAD_NFA: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_next = IDLE;
        end
      end
      STREAM_QUERY: begin
        s_axis_tready = skid_in_ready;
        if (s_axis_tvalid && skid_in_ready && s_axis_tlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept        = s_axis_tvalid && s_axis_tready;
  assign nfa_beat      = accept && (state == LOAD_NFA) && (s_axis_ttype == TTYPE_NFA);
  assign query_beat    = accept && (state == STREAM_QUERY) && (s_axis_ttype == TTYPE_QUERY);
  assign type_mismatch = accept && !nfa_beat && !query_beat;

  // Mismatched beats never reach the skid buffer.
  assign skid_in_valid = (state == STREAM_QUERY) && s_axis_tvalid &&
                         (s_axis_ttype == TTYPE_QUERY);

  // ---------------------------------------------------------------------------
  // Load path, status and error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr        <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      load_done     <= 1'b0;
      nfa_loaded    <= 1'b0;
      nfa_num_lines <= '0;
      nfa_valid     <= 1'b0;
      first_beat    <= 1'b1;
      err_overflow  <= 1'b0;
      err_type      <= 1'b0;
      err_no_nfa    <= 1'b0;
    end else begin
      mem_wr_en  <= 1'b0;
      load_done  <= 1'b0;
      nfa_loaded <= load_done;

      if (state == IDLE) begin
        wr_ptr     <= '0;
        first_beat <= 1'b1;
      end

      if (nfa_beat) begin
        if (!mem_full) begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= wr_ptr[C_MEM_ADDR_WIDTH-1:0];
          mem_wr_data <= s_axis_tdata;
          wr_ptr      <= wr_ptr + 1'b1;
        end else begin
          err_overflow <= 1'b1;
        end
      end

      // tlast ends the load even on a dropped beat; the count then covers only
      // the lines actually written.
      if (accept && (state == LOAD_NFA) && s_axis_tlast) begin
        nfa_valid     <= 1'b1;
        load_done     <= 1'b1;
        nfa_num_lines <= (nfa_beat && !mem_full) ? wr_ptr + 1'b1 : wr_ptr;
      end

      if (accept && (state == STREAM_QUERY)) begin
        first_beat <= 1'b0;
      end

      if (query_beat && first_beat && !nfa_valid) begin
        err_no_nfa <= 1'b1;
      end

      if (type_mismatch) begin
        err_type <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Query path
  // ---------------------------------------------------------------------------
  axis_skid_buffer #(
    .W(C_DATA_WIDTH + 1)
  ) u_query_skid (
    .clk      (aclk),
    .rst      (areset),
    .in_valid (skid_in_valid),
    .in_ready (skid_in_ready),
    .in_data  ({s_axis_tlast, s_axis_tdata}),
    .out_valid(skid_out_valid),
    .out_ready(m_axis_tready),
    .out_data (skid_out_data)
  );

  assign m_axis_tvalid = skid_out_valid;
  assign m_axis_tdata  = skid_out_data[C_DATA_WIDTH-1:0];
  assign m_axis_tlast  = skid_out_data[C_DATA_WIDTH];

`ifdef DISPATCHER_STATS_EN
  // ---------------------------------------------------------------------------
  // Beat counters, keyed on the beat's own ttype (dropped beats included)
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_nfa_lines   <= '0;
      stat_query_lines <= '0;
    end else if (accept) begin
      if (s_axis_ttype == TTYPE_NFA) begin
        stat_nfa_lines <= stat_nfa_lines + 32'd1;
      end else begin
        stat_query_lines <= stat_query_lines + 32'd1;
      end
    end
  end
`endif

endmodule
